// File: rtl/control_logic.sv
// 8259A control block: ICW/OCW decode, configuration registers,
// INTA/poll sequencing, vector and cascade drive.
module control_logic (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] cas_in,
  output logic [2:0] cas_out,
  output logic       cas_io,
  input  logic       sp_n,
  input  logic       intA_n,
  output logic       int_req,
  input  logic [7:0] internal_data_bus,
  input  logic       write_icw_1,
  input  logic       write_icw_2_4,
  input  logic       write_ocw_1,
  input  logic       write_ocw_2,
  input  logic       write_ocw_3,
  input  logic       read,
  output logic       out_control_logic_data,
  output logic [7:0] control_logic_data,
  output logic       level_or_edge_toriggered_config,
  output logic       special_fully_nest_config,
  output logic       enable_read_register,
  output logic       read_register_isr_or_irr,
  input  logic [7:0] interrupt,
  input  logic [7:0] highest_level_in_service,
  output logic [7:0] interrupt_mask,
  output logic [7:0] interrupt_special_mask,
  output logic [7:0] end_of_interrupt,
  output logic [2:0] priority_rotate,
  output logic       freeze,
  output logic       latch_in_service,
  output logic [7:0] clear_interrupt_request
);

  typedef enum logic [1:0] {
    READY, ICW2, ICW3, ICW4
  } init_t;

  typedef enum logic [1:0] {
    CTL_READY, ACK1, ACK2, POLL
  } ctl_t;

  function automatic logic [2:0] idx(input logic [7:0] v);
    idx = 3'd7;
    for (int i = 7; i >= 0; i--)
      if (v[i]) idx = 3'(i);
  endfunction

  init_t init_q, init_d;
  ctl_t  ctl_q, ctl_d;

  logic       ic4, sngl, ltim;
  logic [4:0] vec;
  logic [7:0] cas_cfg;
  logic       aeoi, ms, buf_mode, sfnm;
  logic [7:0] imr;
  logic       auto_rotate, special_mask;
  logic       rr, ris;
  logic       prev_inta_n, prev_read;
  logic [7:0] ack;
  logic       w_ocw1, w_ocw2, w_ocw3;
  logic       inta_fall, inta_rise, read_fall;
  logic       end_seq;
  logic       cas_slave, cas_sel, slave_ir;
  logic [2:0] ack_idx;
  logic [2:0] ocw2_op;

  assign w_ocw1  = write_ocw_1 && init_q == READY;
  assign w_ocw2  = write_ocw_2 && init_q == READY;
  assign w_ocw3  = write_ocw_3 && init_q == READY;
  assign ocw2_op = internal_data_bus[7:5];

  assign inta_fall = prev_inta_n && !intA_n;
  assign inta_rise = !prev_inta_n && intA_n;
  assign read_fall = prev_read && !read;

  // Init sequencer state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) init_q <= READY;
    else        init_q <= init_d;

  // Init sequencer next state: ICW3/ICW4 skipped as configured
  always_comb begin
    init_d = init_q;
    if (write_icw_1) begin
      init_d = ICW2;
    end else if (write_icw_2_4) begin
      unique case (init_q)
        ICW2:    init_d = !sngl ? ICW3 : (ic4 ? ICW4 : READY);
        ICW3:    init_d = ic4 ? ICW4 : READY;
        ICW4:    init_d = READY;
        default: init_d = init_q;
      endcase
    end
  end

  // Configuration registers from ICWs and OCWs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ic4          <= 1'b0;
      sngl         <= 1'b0;
      ltim         <= 1'b0;
      vec          <= '0;
      cas_cfg      <= '0;
      aeoi         <= 1'b0;
      ms           <= 1'b0;
      buf_mode     <= 1'b0;
      sfnm         <= 1'b0;
      imr          <= '0;
      auto_rotate  <= 1'b0;
      special_mask <= 1'b0;
      rr           <= 1'b0;
      ris          <= 1'b0;
    end else if (write_icw_1) begin
      ic4          <= internal_data_bus[0];
      sngl         <= internal_data_bus[1];
      ltim         <= internal_data_bus[3];
      imr          <= '0;
      aeoi         <= 1'b0;
      auto_rotate  <= 1'b0;
      sfnm         <= 1'b0;
      special_mask <= 1'b0;
      rr           <= 1'b1;
      ris          <= 1'b0;
    end else begin
      if (write_icw_2_4) begin
        unique case (init_q)
          ICW2: vec <= internal_data_bus[7:3];
          ICW3: cas_cfg <= internal_data_bus;
          ICW4: begin
            aeoi     <= internal_data_bus[1];
            ms       <= internal_data_bus[2];
            buf_mode <= internal_data_bus[3];
            sfnm     <= internal_data_bus[4];
          end
          default: ;
        endcase
      end
      if (w_ocw1) imr <= internal_data_bus;
      if (w_ocw2 && ocw2_op == 3'b100)
        auto_rotate <= 1'b1;
      if (w_ocw2 && ocw2_op == 3'b000)
        auto_rotate <= 1'b0;
      if (w_ocw3) begin
        if (internal_data_bus[1]) begin
          rr  <= 1'b1;
          ris <= internal_data_bus[0];
        end
        if (internal_data_bus[6])
          special_mask <= internal_data_bus[5];
      end
    end
  end

  // Lowest-priority level: set by OCW2 or auto-rotate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      priority_rotate <= 3'd7;
    else if (write_icw_1)
      priority_rotate <= 3'd7;
    else if (w_ocw2 && ocw2_op == 3'b101)
      priority_rotate <= idx(highest_level_in_service);
    else if (w_ocw2 && ocw2_op[2:1] == 2'b11)
      priority_rotate <= internal_data_bus[2:0];
    else if (end_seq && auto_rotate)
      priority_rotate <= ack_idx;
  end

  // Previous samples for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_inta_n <= 1'b0;
      prev_read   <= 1'b0;
    end else begin
      prev_inta_n <= intA_n;
      prev_read   <= read;
    end
  end

  // Acknowledge sequencer state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ctl_q <= CTL_READY;
    else        ctl_q <= ctl_d;

  // Acknowledge sequencer next state; poll beats INTA
  always_comb begin
    ctl_d = ctl_q;
    unique case (ctl_q)
      CTL_READY: begin
        if (w_ocw3 && internal_data_bus[2])
          ctl_d = POLL;
        else if (inta_fall)
          ctl_d = ACK1;
      end
      ACK1: if (inta_rise) ctl_d = ACK2;
      ACK2: if (inta_rise) ctl_d = CTL_READY;
      POLL: if (read_fall) ctl_d = CTL_READY;
      default: ctl_d = CTL_READY;
    endcase
  end

  assign freeze   = ctl_q != CTL_READY;
  assign latch_in_service =
    ctl_q == CTL_READY && ctl_d != CTL_READY;
  assign end_seq  = (ctl_q == ACK2 || ctl_q == POLL)
                 && ctl_d == CTL_READY;
  assign ack_idx  = idx(ack);

  // Acknowledged level held through the sequence
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                ack <= '0;
    else if (latch_in_service) ack <= interrupt;
    else if (end_seq)          ack <= '0;
  end

  // CPU interrupt line; a new request wins over sequence end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 int_req <= 1'b0;
    else if (interrupt != 8'h0) int_req <= 1'b1;
    else if (end_seq)           int_req <= 1'b0;
  end

  // IRR clear bits
  always_comb begin
    clear_interrupt_request = '0;
    if (write_icw_1)
      clear_interrupt_request = 8'hFF;
    else if (latch_in_service)
      clear_interrupt_request = interrupt;
  end

  // ISR clear from OCW2 commands and auto-EOI
  always_comb begin
    end_of_interrupt = '0;
    if (w_ocw2) begin
      unique case (ocw2_op)
        3'b001, 3'b101:
          end_of_interrupt = highest_level_in_service;
        3'b011, 3'b111:
          end_of_interrupt = 8'd1 << internal_data_bus[2:0];
        default: end_of_interrupt = '0;
      endcase
    end
    if (end_seq && aeoi)
      end_of_interrupt = end_of_interrupt | ack;
  end

  assign cas_slave = sngl ? 1'b0
                   : (!buf_mode ? !sp_n : !ms);
  assign cas_io    = cas_slave;
  assign cas_sel   = cas_in == cas_cfg[2:0];
  assign slave_ir  = (ack & cas_cfg) != 8'h0;

  // Master drives the slave ID during acknowledge
  always_comb begin
    cas_out = '0;
    if (!cas_slave && slave_ir
        && (ctl_q == ACK1 || ctl_q == ACK2))
      cas_out = ack_idx;
  end

  // Vector or poll word onto the data bus
  always_comb begin
    out_control_logic_data = 1'b0;
    control_logic_data     = '0;
    if (ctl_q == ACK2 && !intA_n
        && (sngl || (cas_slave && cas_sel)
            || (!cas_slave && !slave_ir))) begin
      out_control_logic_data = 1'b1;
      control_logic_data     = {vec, ack_idx};
    end else if (ctl_q == POLL && read) begin
      out_control_logic_data = 1'b1;
      control_logic_data     = (ack != 8'h0)
                             ? {5'b10000, ack_idx} : 8'h00;
    end
  end

  assign level_or_edge_toriggered_config = ltim;
  assign special_fully_nest_config       = sfnm;
  assign enable_read_register            = rr;
  assign read_register_isr_or_irr        = ris;
  assign interrupt_mask                  = imr;
  assign interrupt_special_mask =
    special_mask ? imr : 8'h00;

endmodule

// File: tb/tb_control_logic.sv
// Directed bench for control_logic with a scoreboard queue.
// Expected values are queued at stimulus time and popped at checks.
module tb_control_logic;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] cas_in;
  logic [2:0] cas_out;
  logic       cas_io;
  logic       sp_n;
  logic       intA_n;
  logic       int_req;
  logic [7:0] bus;
  logic       write_icw_1, write_icw_2_4;
  logic       write_ocw_1, write_ocw_2, write_ocw_3;
  logic       read;
  logic       out_cl;
  logic [7:0] cl_data;
  logic       ltim_cfg, sfnm_cfg, rr, ris;
  logic [7:0] interrupt, hisr;
  logic [7:0] imr, smask, eoi;
  logic [2:0] rot;
  logic       freeze, latch;
  logic [7:0] clr_irr;

  int total = 0;
  int bad = 0;
  int latch_cnt = 0;
  int l0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  always @(posedge clk) if (latch) latch_cnt++;

  control_logic dut (
    .clk(clk),
    .rst_n(rst_n),
    .cas_in(cas_in),
    .cas_out(cas_out),
    .cas_io(cas_io),
    .sp_n(sp_n),
    .intA_n(intA_n),
    .int_req(int_req),
    .internal_data_bus(bus),
    .write_icw_1(write_icw_1),
    .write_icw_2_4(write_icw_2_4),
    .write_ocw_1(write_ocw_1),
    .write_ocw_2(write_ocw_2),
    .write_ocw_3(write_ocw_3),
    .read(read),
    .out_control_logic_data(out_cl),
    .control_logic_data(cl_data),
    .level_or_edge_toriggered_config(ltim_cfg),
    .special_fully_nest_config(sfnm_cfg),
    .enable_read_register(rr),
    .read_register_isr_or_irr(ris),
    .interrupt(interrupt),
    .highest_level_in_service(hisr),
    .interrupt_mask(imr),
    .interrupt_special_mask(smask),
    .end_of_interrupt(eoi),
    .priority_rotate(rot),
    .freeze(freeze),
    .latch_in_service(latch),
    .clear_interrupt_request(clr_irr)
  );

  task automatic push(input logic [31:0] v);
    sb.push_back(v);
  endtask

  task automatic cmp(input string tag,
                     input logic [31:0] obs);
    logic [31:0] e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL %s: observed %h, queue empty", tag, obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s: observed %h expected %h",
               tag, obs, e);
      end
    end
  endtask

  task automatic drv(input int k, input logic [7:0] d);
    @(negedge clk);
    bus = d;
    case (k)
      0: write_icw_1   = 1'b1;
      1: write_icw_2_4 = 1'b1;
      2: write_ocw_1   = 1'b1;
      3: write_ocw_2   = 1'b1;
      default: write_ocw_3 = 1'b1;
    endcase
  endtask

  task automatic idle();
    @(negedge clk);
    write_icw_1   = 1'b0;
    write_icw_2_4 = 1'b0;
    write_ocw_1   = 1'b0;
    write_ocw_2   = 1'b0;
    write_ocw_3   = 1'b0;
    bus = 8'h00;
  endtask

  task automatic wr(input int k, input logic [7:0] d);
    drv(k, d);
    idle();
  endtask

  initial begin
    rst_n = 1'b0; intA_n = 1'b1; read = 1'b0;
    sp_n = 1'b1; cas_in = 3'd0; bus = 8'h00;
    write_icw_1 = 1'b0; write_icw_2_4 = 1'b0;
    write_ocw_1 = 1'b0; write_ocw_2 = 1'b0;
    write_ocw_3 = 1'b0;
    interrupt = 8'h00; hisr = 8'h00;
    repeat (2) @(negedge clk);
    push(7); push(0); push(0); push(0); push(0);
    push(0); push(0);
    cmp("rst_rotate", rot);
    cmp("rst_int", int_req);
    cmp("rst_freeze", freeze);
    cmp("rst_mask", imr);
    cmp("rst_rr", rr);
    cmp("rst_ltim", ltim_cfg);
    cmp("rst_sfnm", sfnm_cfg);
    rst_n = 1'b1;

    // single mode, ICW4 needed
    drv(0, 8'h13); #1;
    push(8'hFF); cmp("icw1_clr_irr", clr_irr);
    idle();
    push(1); cmp("icw1_rr", rr);
    wr(2, 8'hF0);
    push(0); cmp("ocw1_mid_init", imr);
    wr(1, 8'h48);
    wr(1, 8'h01);
    wr(2, 8'hF0);
    push(8'hF0); cmp("ocw1_mask", imr);

    // INTA sequence on IR3
    @(negedge clk); interrupt = 8'h08;
    @(negedge clk);
    push(1); cmp("int_set", int_req);
    l0 = latch_cnt;
    intA_n = 1'b0; #1;
    push(8'h08); cmp("ack_clr_irr", clr_irr);
    @(negedge clk); interrupt = 8'h00;
    push(1); cmp("ack1_freeze", freeze);
    intA_n = 1'b1;
    @(negedge clk); intA_n = 1'b0; #1;
    push(1); push(8'h4B);
    cmp("ack2_out", out_cl);
    cmp("ack2_vector", cl_data);
    @(negedge clk); intA_n = 1'b1;
    @(negedge clk);
    push(0); push(0); push(1); push(0);
    cmp("ack_done_freeze", freeze);
    cmp("ack_done_int", int_req);
    cmp("latch_once", latch_cnt - l0);
    cmp("ack_done_out", out_cl);

    // OCW2 commands
    hisr = 8'h08;
    drv(3, 8'h63); #1;
    push(8'h08); cmp("eoi_specific", eoi);
    idle(); #1;
    push(0); cmp("eoi_one_cycle", eoi);
    wr(3, 8'hC5);
    push(5); cmp("rotate_set_5", rot);
    hisr = 8'h10;
    drv(3, 8'h20); #1;
    push(8'h10); cmp("eoi_nonspecific", eoi);
    idle();
    drv(3, 8'hA0); #1;
    push(8'h10); cmp("eoi_rot_nonspec", eoi);
    idle();
    push(4); cmp("rotate_nonspec", rot);
    hisr = 8'h00;

    // special mask and read register select
    wr(4, 8'h68);
    push(8'hF0); cmp("smm_on", smask);
    wr(4, 8'h0B);
    push(1); cmp("ris_set", ris);

    // poll on IR5
    drv(4, 8'h0C); interrupt = 8'h20; #1;
    push(1); cmp("poll_latch", latch);
    idle(); interrupt = 8'h00;
    push(1); push(1);
    cmp("poll_freeze", freeze);
    cmp("poll_rr_kept", rr);
    read = 1'b1; #1;
    push(1); push(8'h85);
    cmp("poll_out", out_cl);
    cmp("poll_word", cl_data);
    @(negedge clk); read = 1'b0;
    @(negedge clk);
    push(0); cmp("poll_done", freeze);

    // cascade master, slave on IR2
    drv(0, 8'h11);
    idle();
    push(7); push(0);
    cmp("icw1_rot_reset", rot);
    cmp("icw1_mask_clr", imr);
    wr(1, 8'h48);
    wr(1, 8'h04);
    wr(1, 8'h01);
    push(0); cmp("cas_io_master", cas_io);
    @(negedge clk); interrupt = 8'h04; intA_n = 1'b0;
    @(negedge clk); interrupt = 8'h00;
    push(2); cmp("cas_ack1", cas_out);
    intA_n = 1'b1;
    @(negedge clk);
    push(2); cmp("cas_ack2", cas_out);
    intA_n = 1'b0; #1;
    push(0); cmp("cas_master_out", out_cl);
    @(negedge clk); intA_n = 1'b1;
    @(negedge clk);
    push(0); cmp("cas_done", cas_out);

    // reset during ACK1
    wr(3, 8'hC2);
    push(2); cmp("rotate_set_2", rot);
    @(negedge clk); interrupt = 8'h02; intA_n = 1'b0;
    @(negedge clk); interrupt = 8'h00;
    push(1); cmp("pre_rst_freeze", freeze);
    intA_n = 1'b1;
    rst_n = 1'b0; #1;
    push(0); push(7); push(0); push(0); push(0);
    cmp("mid_rst_freeze", freeze);
    cmp("mid_rst_rotate", rot);
    cmp("mid_rst_int", int_req);
    cmp("mid_rst_rr", rr);
    cmp("mid_rst_out", out_cl);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
